// File: rtl/vga_rx_monitor.sv
// VGA stream receiver/checker: recovers pixel coordinates from HS/VS, checks line/frame timing,
// tracks lock and samples one probe pixel per frame. Optional blanking check: VGA_RX_BLANK_CHECK_EN.
module vga_rx_monitor #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               HS,
    input  logic               VS,
    input  logic [11:0]        VGA_RGB,
    input  logic signed [10:0] probe_x,
    input  logic signed [10:0] probe_y,
    output logic               locked,
    output logic signed [10:0] x_rx,
    output logic signed [10:0] y_rx,
    output logic               sample_valid,
    output logic [11:0]        sample_rgb,
    output logic [7:0]         err_count,
    output logic               blank_err
);
    localparam int          H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int          V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic        ACT     = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_L = 11'(V_TOTAL);
    localparam logic [10:0] X_OFS   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] Y_OFS   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] H_VIS_L = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_L = 11'(V_VISIBLE);

    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic               good_q, good_d;
    logic               hs_q, vs_q, hs_p_q, vs_p_q;
    logic [11:0]        rgb_q;
    logic [10:0]        h_cnt_q, v_cnt_q;
    logic [10:0]        h_cur, v_cur;
    logic               vs_pend_q, vs_seen_q;
    logic signed [10:0] px_q, py_q;
    logic signed [10:0] x_cur, y_cur;
    logic signed [10:0] x_rx_q, y_rx_q;
    logic               sample_valid_q;
    logic [11:0]        sample_rgb_q;
    logic [7:0]         err_q;
    logic               hs_edge, vs_edge, vs_on, v_restart;
    logic               line_err, frame_err, err, hit;

    assign hs_edge   = (hs_q == ACT) && (hs_p_q != ACT);
    assign vs_on     = (vs_q == ACT);
    assign vs_edge   = vs_on && (vs_p_q != ACT);
    // A VS edge seen anywhere in the current line restarts the frame at the next HS edge.
    assign v_restart = hs_edge && vs_on && (vs_pend_q || vs_edge);

    // h_cur/v_cur describe the pixel currently held in rgb_q.
    assign h_cur = hs_edge ? 11'd0 : ((h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 11'd1);
    assign v_cur = !hs_edge ? v_cnt_q :
                   v_restart ? 11'd0 :
                   ((v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 11'd1);

    assign x_cur = $signed(h_cur - X_OFS);
    assign y_cur = $signed(v_cur - Y_OFS);

    // Long lines/frames are flagged once when the count passes the total, so the closing
    // edge only flags short ones; each bad line or frame costs exactly one error.
    assign line_err  = (hs_edge && (({1'b0, h_cnt_q} + 12'd1) < 12'(H_TOTAL)))
                     || (!hs_edge && (h_cur == H_TOT_L));
    assign frame_err = (vs_edge && (({1'b0, v_cnt_q} + 12'd1) < 12'(V_TOTAL)))
                     || (hs_edge && !v_restart && (v_cur == V_TOT_L));
    assign err       = line_err || frame_err;

    assign hit = (state_q == LOCKED)
              && !px_q[10] && ($unsigned(px_q) < H_VIS_L)
              && !py_q[10] && ($unsigned(py_q) < V_VIS_L)
              && (x_cur == px_q) && (y_cur == py_q);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            HUNT: begin
                if (vs_edge) begin
                    state_d = ACQUIRE;
                    good_d  = 1'b0;
                end
            end
            ACQUIRE: begin
                if (err) begin
                    state_d = HUNT;
                end else if (vs_edge) begin
                    if (good_q) begin
                        state_d = LOCKED;
                        good_d  = 1'b0;
                    end else begin
                        good_d  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (err) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HUNT;
            good_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_q      <= ~ACT;
            vs_q      <= ~ACT;
            hs_p_q    <= ~ACT;
            vs_p_q    <= ~ACT;
            rgb_q     <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            vs_pend_q <= 1'b0;
            vs_seen_q <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            x_rx_q    <= '0;
            y_rx_q    <= '0;
        end else begin
            hs_q      <= HS;
            vs_q      <= VS;
            hs_p_q    <= hs_q;
            vs_p_q    <= vs_q;
            rgb_q     <= VGA_RGB;
            h_cnt_q   <= h_cur;
            v_cnt_q   <= v_cur;
            vs_seen_q <= vs_seen_q | vs_edge;
            if (hs_edge)      vs_pend_q <= 1'b0;
            else if (vs_edge) vs_pend_q <= 1'b1;
            if (vs_edge) begin
                px_q <= probe_x;
                py_q <= probe_y;
            end
            x_rx_q    <= x_cur;
            y_rx_q    <= y_cur;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_valid_q <= 1'b0;
            sample_rgb_q   <= '0;
            err_q          <= '0;
        end else begin
            sample_valid_q <= hit;
            if (hit) sample_rgb_q <= rgb_q;
            if (err && vs_seen_q && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

`ifdef VGA_RX_BLANK_CHECK_EN
    logic blank_q;
    logic in_vis;

    assign in_vis = !x_cur[10] && ($unsigned(x_cur) < H_VIS_L)
                 && !y_cur[10] && ($unsigned(y_cur) < V_VIS_L);

    always_ff @(posedge CLK) begin
        if (RST) begin
            blank_q <= 1'b0;
        end else if ((state_q == LOCKED) && (rgb_q != 12'h000) && !in_vis) begin
            blank_q <= 1'b1;
        end
    end

    assign blank_err = blank_q;
`else
    assign blank_err = 1'b0;
`endif

    assign locked       = (state_q == LOCKED);
    assign x_rx         = x_rx_q;
    assign y_rx         = y_rx_q;
    assign sample_valid = sample_valid_q;
    assign sample_rgb   = sample_rgb_q;
    assign err_count    = err_q;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a reduced 25x19 timing; probe samples go through a scoreboard
// queue pushed when the probe pixel is driven and popped when sample_valid fires.
module tb_vga_rx_monitor;
    localparam int HV = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
`ifdef VGA_RX_BLANK_CHECK_EN
    localparam logic EXP_BLANK = 1'b1;
`else
    localparam logic EXP_BLANK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, hs, vs;
    logic [11:0]        rgb;
    logic signed [10:0] px, py;
    logic               locked, sample_valid, blank_err;
    logic signed [10:0] x_rx, y_rx;
    logic [11:0]        sample_rgb;
    logic [7:0]         err_count;

    vga_rx_monitor #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .CLK(clk), .RST(rst), .HS(hs), .VS(vs), .VGA_RGB(rgb),
        .probe_x(px), .probe_y(py), .locked(locked), .x_rx(x_rx), .y_rx(y_rx),
        .sample_valid(sample_valid), .sample_rgb(sample_rgb),
        .err_count(err_count), .blank_err(blank_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] rgb; int at; } exp_t;
    exp_t               sb[$];
    int                 compared = 0, mismatched = 0, cyc = 0, n_samp = 0;
    int                 vs_since = 0;
    logic signed [10:0] sh_x = '0, sh_y = '0;

    // One clock; the scoreboard is drained here since samples can appear in any test.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (sample_valid === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL sample_unexpected: got rgb=%h at cycle %0d, required no sample", sample_rgb, cyc);
            end else begin
                e = sb.pop_front();
                n_samp++;
                if (sample_rgb !== e.rgb || cyc != e.at) begin
                    mismatched++;
                    $display("FAIL sample_rgb: got %h at cycle %0d, required %h at cycle %0d", sample_rgb, cyc, e.rgb, e.at);
                end
            end
        end
    endtask

    task automatic drive_pix(input int gh, input int gv, input bit vs_en, input int blank_ln);
        int          x, y;
        logic [11:0] c;
        exp_t        e;
        if (gh == 0 && gv == 0) begin
            if (vs_en) begin
                sh_x = px;
                sh_y = py;
                if (vs_since < 3) vs_since++;
            end else begin
                vs_since = 0;
            end
        end
        hs = (gh < HSY) ? 1'b0 : 1'b1;
        vs = (vs_en && gv < VSY) ? 1'b0 : 1'b1;
        x = gh - (HSY + HB);
        y = gv - (VSY + VB);
        c = 12'h000;
        if (x >= 0 && x < HV && y >= 0 && y < VV) begin
            if (x == 5 && y == 4)      c = 12'hF80;
            else if (x == 5 && y == 8) c = 12'h0A5;
            else                       c = {x[3:0], y[3:0], 4'h1};
            if (vs_since >= 3 && x == int'(sh_x) && y == int'(sh_y)) begin
                e.rgb = c;
                e.at  = cyc + 2;
                sb.push_back(e);
            end
        end
        if (gv == blank_ln && gh == 2) c = 12'h00F;
        rgb = c;
        step();
    endtask

    task automatic run_frame(input int long_ln, input bit vs_en, input int chg_ln, input int chg_y, input int blank_ln);
        for (int gv = 0; gv < VT; gv++) begin
            if (gv == chg_ln) py = 11'(chg_y);
            for (int gh = 0; gh < HT; gh++) drive_pix(gh, gv, vs_en, blank_ln);
            if (gv == long_ln) begin
                vs_since = 0;
                drive_pix(HT, gv, vs_en, blank_ln);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hs = 1'b1; vs = 1'b1; rgb = '0; px = 11'sd5; py = 11'sd4;
        repeat (3) step();
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked: got %b required 0", locked); end
        compared++; if (x_rx !== 11'sd0) begin mismatched++; $display("FAIL reset_x_rx: got %0d required 0", x_rx); end
        compared++; if (y_rx !== 11'sd0) begin mismatched++; $display("FAIL reset_y_rx: got %0d required 0", y_rx); end
        compared++; if (sample_valid !== 1'b0) begin mismatched++; $display("FAIL reset_sample_valid: got %b required 0", sample_valid); end
        compared++; if (sample_rgb !== 12'h000) begin mismatched++; $display("FAIL reset_sample_rgb: got %h required 000", sample_rgb); end
        compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL reset_err_count: got %0d required 0", err_count); end
        compared++; if (blank_err !== 1'b0) begin mismatched++; $display("FAIL reset_blank_err: got %b required 0", blank_err); end
        vs_since = 0; sh_x = '0; sh_y = '0;
        rst = 1'b0;
    endtask

    task automatic test_lock();
        n_samp = 0;
        run_frame(-1, 1, -1, 0, -1);
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL lock_early: got %b required 0", locked); end
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL lock_third_edge: got %b required 1", locked); end
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL lock_err_count: got %0d required 0", err_count); end
        compared++; if (n_samp != 2) begin mismatched++; $display("FAIL lock_samples: got %0d required 2", n_samp); end
        compared++; if (sample_rgb !== 12'hF80) begin mismatched++; $display("FAIL lock_sample_rgb: got %h required F80", sample_rgb); end
    endtask

    task automatic test_probe_change();
        n_samp = 0;
        run_frame(-1, 1, 2, 8, -1);
        compared++; if (sample_rgb !== 12'hF80) begin mismatched++; $display("FAIL probe_old_frame: got %h required F80", sample_rgb); end
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (sample_rgb !== 12'h0A5) begin mismatched++; $display("FAIL probe_new_frame: got %h required 0A5", sample_rgb); end
        compared++; if (n_samp != 2) begin mismatched++; $display("FAIL probe_samples: got %0d required 2", n_samp); end
    endtask

    task automatic test_long_line();
        run_frame(3, 1, -1, 0, -1);
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL long_unlock: got %b required 0", locked); end
        compared++; if (err_count !== 8'd1) begin mismatched++; $display("FAIL long_err_count: got %0d required 1", err_count); end
        run_frame(-1, 1, -1, 0, -1);
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL long_relock_early: got %b required 0", locked); end
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL long_relock: got %b required 1", locked); end
        compared++; if (err_count !== 8'd1) begin mismatched++; $display("FAIL long_err_hold: got %0d required 1", err_count); end
    endtask

    task automatic test_vs_missing();
        run_frame(-1, 0, -1, 0, -1);
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL vsmiss_unlock: got %b required 0", locked); end
        compared++; if (err_count !== 8'd2) begin mismatched++; $display("FAIL vsmiss_err_count: got %0d required 2", err_count); end
        run_frame(-1, 1, -1, 0, -1);
        run_frame(-1, 1, -1, 0, -1);
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL vsmiss_relock: got %b required 1", locked); end
        compared++; if (err_count !== 8'd2) begin mismatched++; $display("FAIL vsmiss_err_hold: got %0d required 2", err_count); end
    endtask

    task automatic test_blank();
        run_frame(-1, 1, -1, 0, 10);
        compared++; if (blank_err !== EXP_BLANK) begin mismatched++; $display("FAIL blank_err: got %b required %b", blank_err, EXP_BLANK); end
        compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL blank_locked: got %b required 1", locked); end
        compared++; if (err_count !== 8'd2) begin mismatched++; $display("FAIL blank_err_count: got %0d required 2", err_count); end
    endtask

    task automatic test_reset_midline();
        for (int gv = 0; gv < 7; gv++)
            for (int gh = 0; gh < HT; gh++) drive_pix(gh, gv, 1, -1);
        for (int gh = 0; gh < 11; gh++) drive_pix(gh, 7, 1, -1);
        rst = 1'b1;
        drive_pix(11, 7, 1, -1);
        rst = 1'b0;
        vs_since = 0; sh_x = '0; sh_y = '0;
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL midrst_locked: got %b required 0", locked); end
        compared++; if (sample_rgb !== 12'h000) begin mismatched++; $display("FAIL midrst_sample_rgb: got %h required 000", sample_rgb); end
        compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL midrst_err_count: got %0d required 0", err_count); end
        compared++; if (blank_err !== 1'b0) begin mismatched++; $display("FAIL midrst_blank_err: got %b required 0", blank_err); end
        compared++; if (x_rx !== 11'sd0 || y_rx !== 11'sd0) begin mismatched++; $display("FAIL midrst_xy: got %0d,%0d required 0,0", x_rx, y_rx); end
        n_samp = 0;
        run_frame(-1, 1, -1, 0, -1);
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b0 || n_samp != 0) begin mismatched++; $display("FAIL midrst_early: got locked=%b samples=%0d required 0,0", locked, n_samp); end
        run_frame(-1, 1, -1, 0, -1);
        compared++; if (locked !== 1'b1 || n_samp != 1) begin mismatched++; $display("FAIL midrst_relock: got locked=%b samples=%0d required 1,1", locked, n_samp); end
        compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL midrst_err_hold: got %0d required 0", err_count); end
    endtask

    task automatic test_saturate();
        rst = 1'b1; hs = 1'b1; vs = 1'b1; rgb = '0;
        step();
        rst = 1'b0;
        vs_since = 0;
        for (int ln = 0; ln < 300; ln++) begin
            for (int gh = 0; gh < 10; gh++) begin
                hs = (gh < 2) ? 1'b0 : 1'b1;
                vs = (ln < 2) ? 1'b0 : 1'b1;
                step();
            end
        end
        compared++; if (err_count !== 8'd255) begin mismatched++; $display("FAIL sat_err_count: got %0d required 255", err_count); end
        compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL sat_locked: got %b required 0", locked); end
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; rgb = '0; px = 11'sd5; py = 11'sd4;
        test_reset();
        test_lock();
        test_probe_change();
        test_long_line();
        test_vs_missing();
        test_blank();
        test_reset_midline();
        test_saturate();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: got %0d pending samples required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
